// File: rtl/johnson_checker_pkg.sv
// Shared types and constants for Johnson-code consumers: FSM states, default phase geometry
// and the error tally ceiling.
package johnson_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int NPH       = 2 * DEF_WIDTH;
  localparam int PH_W      = $clog2(NPH);
  localparam int ERR_MAX   = 255;

endpackage

// File: rtl/johnson_checker_if.sv
// Sample/status bundle between a Johnson code source and johnson_checker.
// One_hot exists only when JOHNSON_CHECKER_ONEHOT_EN is defined.
interface johnson_checker_if #(
  parameter int WIDTH = 4
);
  localparam int NPH  = 2 * WIDTH;
  localparam int PH_W = $clog2(NPH);

  logic [WIDTH-1:0] Count_in;
  logic             Sample_en;
  logic [PH_W-1:0]  Phase;
  logic             Phase_valid;
  logic             Locked;
  logic             Seq_error;
  logic             Wrap;
  logic [7:0]       Err_count;
`ifdef JOHNSON_CHECKER_ONEHOT_EN
  logic [NPH-1:0]   One_hot;
`endif

  modport master (
    output Count_in, Sample_en,
    input  Phase, Phase_valid, Locked, Seq_error, Wrap, Err_count
`ifdef JOHNSON_CHECKER_ONEHOT_EN
    , input One_hot
`endif
  );

  modport slave (
    input  Count_in, Sample_en,
    output Phase, Phase_valid, Locked, Seq_error, Wrap, Err_count
`ifdef JOHNSON_CHECKER_ONEHOT_EN
    , output One_hot
`endif
  );

endinterface

// File: rtl/johnson_checker_phase_decode.sv
// Combinational Johnson word decoder: maps a WIDTH-bit code to {legal, phase index 0..2*WIDTH-1}.
module johnson_phase_decode #(
  parameter int WIDTH = 4,
  parameter int PH_W  = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] i_code,
  output logic             o_legal,
  output logic [PH_W-1:0]  o_phase
);

  // Phases below WIDTH fill ones from the LSB; the upper half fills zeros from the LSB.
  function automatic logic [WIDTH-1:0] johnson_code(input int p);
    logic [WIDTH-1:0] code;
    for (int i = 0; i < WIDTH; i++)
      code[i] = (p < WIDTH) ? (i < p) : (i >= p - WIDTH);
    return code;
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    o_legal = 1'b0;
    o_phase = '0;
    for (int p = 0; p < 2 * WIDTH; p++) begin
      if (i_code == johnson_code(p)) begin
        o_legal = 1'b1;
        o_phase = PH_W'(p);
      end
    end
  end

endmodule

// File: rtl/johnson_checker.sv
// Johnson sequence checker: decodes sampled words, tracks HUNT/CHECK/LOCKED and reports errors/wraps.
// Optional One_hot output enabled by defining JOHNSON_CHECKER_ONEHOT_EN.
module johnson_checker
  import johnson_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  johnson_checker_if.slave bus
);

  localparam int LNPH  = 2 * WIDTH;
  localparam int LPH_W = $clog2(LNPH);

  logic              w_legal;
  logic [LPH_W-1:0]  w_phase;
  logic              w_is_adv;
  logic              w_is_stall;
  logic              w_err;
  logic              w_wrap;
  state_t            w_state_nxt;
  logic [3:0]        w_gcnt_nxt;
  logic [3:0]        w_gcnt_inc;

  state_t            r_state;
  logic [LPH_W-1:0]  r_p;
  logic [3:0]        r_gcnt;
  logic              r_phase_valid;
  logic              r_locked;
  logic              r_seq_error;
  logic              r_wrap;
  logic [7:0]        r_err_count;

  johnson_phase_decode #(.WIDTH(WIDTH), .PH_W(LPH_W)) u_decode (
    .i_code  (bus.Count_in),
    .o_legal (w_legal),
    .o_phase (w_phase)
  );

  assign w_is_stall = (w_phase == r_p);
  assign w_is_adv   = (w_phase == ((r_p == LPH_W'(LNPH - 1)) ? '0 : r_p + 1'b1));
  assign w_gcnt_inc = r_gcnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_gcnt_nxt  = r_gcnt;
    w_err       = 1'b0;
    w_wrap      = 1'b0;
    if (bus.Sample_en) begin
      if (!w_legal) begin
        w_err       = 1'b1;
        w_state_nxt = HUNT;
        w_gcnt_nxt  = '0;
      end else begin
        unique case (r_state)
          HUNT: begin
            w_state_nxt = CHECK;
            w_gcnt_nxt  = '0;
          end
          CHECK, LOCKED: begin
            if (w_is_adv) begin
              w_wrap = (r_p == LPH_W'(LNPH - 1));
              if (r_state == CHECK) begin
                w_gcnt_nxt = w_gcnt_inc;
                if (w_gcnt_inc >= 4'(LOCK_CNT)) w_state_nxt = LOCKED;
              end
            end else if (!w_is_stall) begin
              // A jump restarts the qualification run from the new phase.
              w_err       = 1'b1;
              w_gcnt_nxt  = '0;
              w_state_nxt = CHECK;
            end
          end
          default: w_state_nxt = HUNT;
        endcase
      end
    end
  end

  // NOTE: reset is synchronous and sampled inside the clocked block; state uses non-blocking updates only.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= HUNT;
      r_p           <= '0;
      r_gcnt        <= '0;
      r_phase_valid <= 1'b0;
      r_locked      <= 1'b0;
      r_seq_error   <= 1'b0;
      r_wrap        <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_seq_error <= w_err;
      r_wrap      <= w_wrap;
      if (bus.Sample_en) begin
        r_state       <= w_state_nxt;
        r_gcnt        <= w_gcnt_nxt;
        r_locked      <= (w_state_nxt == LOCKED);
        r_phase_valid <= w_legal;
        if (w_legal) r_p <= w_phase;
        if (w_err && (r_err_count != 8'(ERR_MAX))) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

`ifdef JOHNSON_CHECKER_ONEHOT_EN
  logic [LNPH-1:0] w_one_hot;
  logic [LNPH-1:0] r_one_hot;

  always_comb begin
    w_one_hot = '0;
    if (w_legal) w_one_hot[w_phase] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset)               r_one_hot <= '0;
    else if (bus.Sample_en)  r_one_hot <= w_one_hot;
  end

  assign bus.One_hot = r_one_hot;
`endif

  assign bus.Phase       = r_p;
  assign bus.Phase_valid = r_phase_valid;
  assign bus.Locked      = r_locked;
  assign bus.Seq_error   = r_seq_error;
  assign bus.Wrap        = r_wrap;
  assign bus.Err_count   = r_err_count;

endmodule

// File: tb/tb_johnson_checker.sv
// Directed self-checking bench for johnson_checker (WIDTH=4, LOCK_CNT=4); checks One_hot when
// JOHNSON_CHECKER_ONEHOT_EN is defined.
module tb_johnson_checker;

  logic Clock;
  logic Reset;
  int   n_assert;
  int   n_fail;

  johnson_checker_if #(.WIDTH(4)) jc_if ();

  johnson_checker #(.WIDTH(4), .LOCK_CNT(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (jc_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] word, input logic en);
    jc_if.Count_in  = word;
    jc_if.Sample_en = en;
    @(posedge Clock);
    #1;
  endtask

  task automatic check_all(input string tag, input int ph, input bit pv, input bit lk,
                           input bit se, input bit wr, input int ec);
    check({tag, ".phase"},  32'(jc_if.Phase),       32'(ph));
    check({tag, ".pvalid"}, 32'(jc_if.Phase_valid), 32'(pv));
    check({tag, ".locked"}, 32'(jc_if.Locked),      32'(lk));
    check({tag, ".seqerr"}, 32'(jc_if.Seq_error),   32'(se));
    check({tag, ".wrap"},   32'(jc_if.Wrap),        32'(wr));
    check({tag, ".errcnt"}, 32'(jc_if.Err_count),   32'(ec));
  endtask

  logic [3:0] seq [8];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    // Reset, with a legal word presented to confirm reset priority.
    Reset = 1'b1;
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    check_all("reset", 0, 0, 0, 0, 0, 0);
`ifdef JOHNSON_CHECKER_ONEHOT_EN
    check("reset.onehot", 32'(jc_if.One_hot), 32'h0);
`endif
    Reset = 1'b0;

    // Clean stream: lock after the 5th sample (4th advance), wrap on 1000->0000.
    for (int i = 0; i < 8; i++) begin
      step(seq[i], 1'b1);
      check_all($sformatf("stream%0d", i), i, 1, (i >= 4), 0, 0, 0);
    end
    step(4'b0000, 1'b1);
    check_all("wrap", 0, 1, 1, 0, 1, 0);
    step(4'b0001, 1'b1);
    check_all("post_wrap", 1, 1, 1, 0, 0, 0);

    // Illegal word while locked.
    step(4'b0101, 1'b1);
    check_all("illegal", 1, 0, 0, 1, 0, 1);
    step(4'b0101, 1'b0);
    check_all("idle_after_illegal", 1, 0, 0, 0, 0, 1);

    // Relock from HUNT, walk to phase 2.
    step(4'b0000, 1'b1);
    check_all("hunt_to_check", 0, 1, 0, 0, 0, 1);
    for (int i = 1; i < 8; i++) step(seq[i], 1'b1);
    check("relock.locked", 32'(jc_if.Locked), 32'd1);
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0011, 1'b1);
    check_all("locked_ph2", 2, 1, 1, 0, 0, 1);

    // Jump 2 -> 5, then four advances (one wrapping) to relock.
    step(4'b1110, 1'b1);
    check_all("jump", 5, 1, 0, 1, 0, 2);
    step(4'b1100, 1'b1);
    check_all("jump_adv1", 6, 1, 0, 0, 0, 2);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    check_all("jump_adv3_wrap", 0, 1, 0, 0, 1, 2);
    step(4'b0001, 1'b1);
    check_all("jump_relock", 1, 1, 1, 0, 0, 2);
    step(4'b0011, 1'b1);
    step(4'b0111, 1'b1);

    // Stall at phase 3 with Sample_en toggling; garbage on disabled cycles must be ignored.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(4'b0111, 1'b1);
      else            step(4'b1010, 1'b0);
      check_all($sformatf("stall%0d", i), 3, 1, 1, 0, 0, 2);
    end
`ifdef JOHNSON_CHECKER_ONEHOT_EN
    check("stall.onehot", 32'(jc_if.One_hot), 32'h08);
`endif

    // One-cycle reset while locked.
    Reset = 1'b1;
    step(4'b0111, 1'b1);
    Reset = 1'b0;
    check_all("mid_reset", 0, 0, 0, 0, 0, 0);
`ifdef JOHNSON_CHECKER_ONEHOT_EN
    check("mid_reset.onehot", 32'(jc_if.One_hot), 32'h0);
`endif

    // 300 illegal words: pulse every cycle, tally saturates at 255.
    for (int i = 0; i < 300; i++) begin
      step(4'b1010, 1'b1);
      check($sformatf("sat%0d.seqerr", i), 32'(jc_if.Seq_error), 32'd1);
      check($sformatf("sat%0d.errcnt", i), 32'(jc_if.Err_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    step(4'b1010, 1'b0);
    check_all("sat_idle", 0, 0, 0, 0, 0, 255);
    step(4'b0000, 1'b1);
    check_all("sat_recover", 0, 1, 0, 0, 0, 255);
`ifdef JOHNSON_CHECKER_ONEHOT_EN
    check("recover.onehot", 32'(jc_if.One_hot), 32'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
